// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe transaction-block feeders: FSM state
// encodings and the field layout of the 6-bit {VC, dest, data} word.
package pcie_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } estado_t;

    localparam int WIDTH_DEF = 6;
    localparam int VC_BIT    = 5;
    localparam int DEST_BIT  = 4;
    localparam int DATA_MSB  = 3;

endpackage

// File: rtl/fifo_sinc.sv
// Parameterised synchronous FIFO (power-of-two depth) with write/read strobes,
// full/empty flags derived from a registered occupancy count, and a flush.
module fifo_sinc #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok_s, rd_ok_s;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == {CW{1'b0}});
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign wr_ok_s = wr && !full && !flush;
    assign rd_ok_s = rd && !empty && !flush;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_ok_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_ok_s) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/alimentador_mf.sv
// Ingress feeder for the main FIFO: buffers source words in a local FIFO and
// forwards them while the main FIFO is neither pausing nor in error.
module alimentador_mf
    import pcie_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             pausa_mf,
    input  logic             error_in,
    output logic             push,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] cnt_vc0,
    output logic [CNT_W-1:0] cnt_vc1,
    output logic [1:0]       estado,
    output logic             vacio
);

    estado_t          state_q, state_d;
    logic             push_q, push_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic                  fifo_wr_s, fifo_rd_s, fifo_flush_s;
    logic [WIDTH-1:0]      fifo_head_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_count_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    fifo_sinc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (fifo_flush_s),
        .wr      (fifo_wr_s),
        .wr_data (in_data),
        .rd      (fifo_rd_s),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Ready comes from registered state and occupancy, so a pop cannot open a full FIFO early.
    assign in_ready = (state_q == ST_RUN) && !fifo_full_s;
    assign vacio    = (fifo_count_s == {($clog2(DEPTH)+1){1'b0}});
    assign push     = push_q;
    assign data_out = data_q;
    assign cnt_vc0  = cnt0_q;
    assign cnt_vc1  = cnt1_q;
    assign estado   = state_q;

    // State transitions, handshake and forwarding decisions.
    always_comb begin
        state_d      = state_q;
        push_d       = 1'b0;
        data_d       = data_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        fifo_wr_s    = 1'b0;
        fifo_rd_s    = 1'b0;
        fifo_flush_s = 1'b0;
        if (init) begin
            state_d      = ST_INIT;
            fifo_flush_s = 1'b1;
            cnt0_d       = {CNT_W{1'b0}};
            cnt1_d       = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_INIT:  state_d = ST_RUN;
                ST_RUN: begin
                    fifo_wr_s = in_valid && in_ready;
                    if (error_in) begin
                        state_d = ST_ERROR;
                    end else if (!pausa_mf && !fifo_empty_s) begin
                        fifo_rd_s = 1'b1;
                        push_d    = 1'b1;
                        data_d    = fifo_head_s;
                        if (fifo_head_s[VC_BIT]) begin
                            cnt1_d = sat_inc(cnt1_q);
                        end else begin
                            cnt0_d = sat_inc(cnt0_q);
                        end
                    end else begin
                        push_d = 1'b0;
                    end
                end
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            push_q  <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
            cnt0_q  <= {CNT_W{1'b0}};
            cnt1_q  <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            push_q  <= push_d;
            data_q  <= data_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

endmodule

// File: doc/alimentador_mf.md
# alimentador_mf

Ingress feeder that sits directly upstream of the PCIe transaction block's main FIFO. It accepts 6-bit words ({VC, dest, data[3:0]}) from a source over a valid/ready handshake and buffers them in a small local FIFO. It issues `push`/`data` to the main FIFO only while that FIFO is not pausing and has not flagged an error. It also keeps per-VC counts of forwarded words for the bench and for debug.

## Interface
Parameters:
- WIDTH, 6, word width; bit 5 = VC select, bit 4 = destination, bits 3:0 = payload
- DEPTH, 4, local FIFO entries (power of two)
- CNT_W, 8, width of per-VC forwarded-word counters

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- init  in  1  re-initialise: flush local FIFO, clear counters
- in_valid  in  1  source word valid
- in_data  in  WIDTH  source word
- in_ready  out  1  block can accept in_data this cycle
- pausa_mf  in  1  main FIFO almost-full (Pausa_MF)
- error_in  in  1  error flag from transaction block (error_out)
- push  out  1  write strobe to main FIFO
- data_out  out  WIDTH  word to main FIFO, valid when push=1
- cnt_vc0  out  CNT_W  words forwarded with bit5=0
- cnt_vc1  out  CNT_W  words forwarded with bit5=1
- estado  out  2  FSM state encoding
- vacio  out  1  local FIFO empty

## Operation
- FSM states: IDLE=0, INIT=1, RUN=2, ERROR=3.
- reset → IDLE. IDLE: in_ready=0, push=0. Leaves only via init=1 → INIT.
- INIT (while init=1, from any state): FIFO pointers/count cleared, counters cleared, in_ready=0, push=0. When init=0 → RUN.
- RUN: in_ready = !full. A word is accepted on any edge with in_valid && in_ready.
- RUN, forwarding: if pausa_mf=0 and FIFO not empty, push<=1, data_out<=head, and head is popped. Otherwise push<=0 and data_out holds its last value.
- RUN → ERROR on error_in=1. In ERROR: push=0, in_ready=0, FIFO contents retained and frozen, counters frozen.
- ERROR exits only via init (→ INIT) or reset.
- init has priority over error_in. reset has priority over everything.
- Counters: on each cycle push is driven 1, increment cnt_vc0 or cnt_vc1 according to data_out[5]. Counters saturate at 2^CNT_W−1 and do not wrap.
- Full FIFO with simultaneous pop: in_ready stays low (it is computed from the registered count). No bypass.
- Empty FIFO with in_valid: the word is written; it can be forwarded no earlier than the next edge. No same-cycle passthrough.
- vacio = (count==0), registered.

## Timing
- Reset values: push=0, data_out=0, in_ready=0, cnt_vc0=0, cnt_vc1=0, estado=IDLE, vacio=1.
- Latency, accept to push: a word accepted at edge N appears with push=1 after edge N+1, given RUN, pausa_mf=0 and nothing ahead of it.
- pausa_mf is sampled at the edge. pausa_mf=1 at edge N means push=0 after edge N. A push already visible before edge N completes normally.
- Throughput: one word per cycle in steady state with pausa_mf=0.
- error_in=1 at edge N: push=0 after edge N. The word that would have been popped stays in the FIFO.
- Reset or init mid-stream: buffered words are discarded, not forwarded.
- Order is strictly FIFO. Word content is never modified.

## Structure
- Shared package (`pcie_pkg`):
  - state encodings IDLE/INIT/RUN/ERROR
  - field positions VC_BIT=5, DEST_BIT=4, DATA_MSB=3
  - WIDTH default
- Sub-module: `fifo_sinc`, a parameterised synchronous FIFO with wr/rd/full/empty/count. It is the same style as the main/VC/D FIFOs and is reusable by them.
- Top: FSM, handshake/forward logic and saturating counters around `fifo_sinc`.

## Test plan
- Reset and init:
  - Stimulus: reset=1 for 2 cycles, then init pulse of 1 cycle.
  - Required: all outputs at reset values; estado goes IDLE→INIT→RUN; in_ready=1 in RUN.
- Burst forward:
  - Stimulus: push 6'b011011, 6'b101101, 6'b000011, 6'b011010 on consecutive cycles, pausa_mf=0.
  - Required: push=1 for 4 consecutive cycles starting 1 cycle after the first accept; data_out in the same order; cnt_vc0=3, cnt_vc1=1.
- Pause and fill:
  - Stimulus: pausa_mf=1, offer 6 words.
  - Required: exactly 4 accepted, then in_ready=0; push=0 throughout.
  - Then release pausa_mf: 4 pushes, and in_ready=1 again once the count drops below 4.
- Error freeze:
  - Stimulus: error_in=1 with 2 words buffered.
  - Required: estado=ERROR; push=0; in_ready=0; vacio=0.
  - Then init pulse: vacio=1, counters=0, estado returns to RUN.
- Counter saturation:
  - Stimulus: CNT_W=2, forward 5 words with bit5=1.
  - Required: cnt_vc1 stops at 3.
- Reset mid-stream:
  - Stimulus: reset=1 while 3 words are buffered and push=1.
  - Required: push=0 and vacio=1 after the edge; no buffered word appears after init.
